sequential_divider: RTL
=======================

# sequential_divider

Multi-cycle restoring shift-subtract divider, the inverse counterpart of the team's shift-add sequential multiplier. Accepts a WIDTH-bit dividend and divisor on a start strobe and produces one quotient bit per clock. Quotient and remainder are held stable after a one-cycle done pulse. Sits alongside the multiplier in the arithmetic unit and uses the same start-driven, single-clock control style.

## Interface

- WIDTH, 16, operand, quotient and remainder width; must be ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  numerator; captured on the accepted start edge.
- divisor  input  WIDTH  denominator; captured on the accepted start edge.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse in DONE; results valid.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor == 0; held with the results.

## Operation

- FSM states: IDLE, CALC, DONE.
- IDLE → CALC when start=1 and divisor≠0.
  - Load the working quotient register Q with dividend.
  - Clear the partial remainder A (WIDTH+1 bits) and the counter.
  - Latch the divisor M.
- IDLE → DONE when start=1 and divisor=0. This path does not enter CALC.
  - quotient = all ones, remainder = dividend, div_by_zero = 1.
- CALC, one iteration per cycle:
  - Shift {A,Q} left by 1.
  - Compute A' = A − {0,M}.
  - If A' ≥ 0: A = A' and Q[0] = 1.
  - Else: A is restored (unchanged) and Q[0] = 0.
  - Increment the counter.
- CALC → DONE after iteration WIDTH (counter == WIDTH−1 at that edge).
  - Registers quotient = Q and remainder = A[WIDTH−1:0]; div_by_zero = 0.
- DONE → IDLE unconditionally after 1 cycle.
- start is ignored in CALC and DONE. It is not queued.
- Operand inputs may change freely after the accepted start edge.
- Result invariant (unsigned): dividend = quotient·divisor + remainder, with remainder < divisor.
- Reset behaviour:
  - Reset high at any edge forces IDLE, including mid-CALC, and discards the operation.
  - Reset clears busy, done, quotient, remainder, div_by_zero and all internal registers to 0.

## Timing

- Cycle 0: start=1 in IDLE; operands captured at the closing edge.
- Cycles 1..WIDTH: CALC with busy=1. With WIDTH=16, busy is high for exactly 16 cycles.
- Cycle WIDTH+1: DONE with done=1 and busy=0; outputs already hold the final values.
- Cycle WIDTH+2: IDLE; the earliest next start is accepted here.
  - Back-to-back throughput is one operation per WIDTH+2 cycles.
- Divide-by-zero path: done=1 in cycle 1. Total latency is 1 cycle.
- busy and done are never high together.
- quotient and remainder change only on the DONE-entry edge or on reset.

## Configuration

- SEQ_DIVIDER_SIGNED_EN
  - **Defined:** operands are two's complement.
    - Magnitudes are taken at load.
    - Quotient sign = sign(dividend) XOR sign(divisor), truncation toward zero.
    - Remainder sign follows the dividend.
    - Sign fix-up is applied on the DONE-entry edge, so latency is unchanged.
    - Divide-by-zero gives quotient = −1 (all ones) and remainder = dividend.
    - Most-negative ÷ −1 gives quotient = most-negative and remainder = 0, with no error flag.
  - **Undefined:** purely unsigned operation as described above. No sign logic is synthesized.

## Test plan

- **Basic unsigned:** dividend=100, divisor=7, start for 1 cycle → busy high 16 cycles; done in cycle 17; quotient=14, remainder=2, div_by_zero=0.
- **Edge values:** 0xFFFF/0x0001 → quotient=0xFFFF, remainder=0. 0x0005/0x0009 → quotient=0, remainder=5. 0x0000/0x1234 → quotient=0, remainder=0.
- **Divide by zero:** 0x1234/0 → done in cycle 1 with busy never high; quotient=0xFFFF, remainder=0x1234, div_by_zero=1. A following 10/3 clears div_by_zero with quotient=3, remainder=1.
- **Start handling:** hold start high continuously with operands 50/5 → operations complete every 18 cycles with quotient=10, remainder=0. A start pulse in cycle 5 with different operands has no effect.
- **Reset mid-operation:** assert reset in cycle 8 of 1000/3 → next cycle all outputs are 0 and the state is IDLE. A new 1000/3 then gives quotient=333, remainder=1.
- **Signed (SEQ_DIVIDER_SIGNED_EN):**
  - −7/2 → quotient=−3, remainder=−1.
  - 7/−2 → quotient=−3, remainder=1.
  - 0x8000/0xFFFF → quotient=0x8000, remainder=0.
  - Random 1000-vector check against the reference model.

Source files
------------

// File: rtl/sequential_divider_if.sv
// sequential_divider_if: start/operand request and busy/done/result response bundle of the divider
interface sequential_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/sequential_divider.sv
// sequential_divider: restoring shift-subtract divider, one quotient bit per clock; SEQ_DIVIDER_SIGNED_EN selects two's-complement operands
module sequential_divider #(
    parameter int WIDTH = 16
) (
    input logic                 clk_i,
    input logic                 reset_i,
    sequential_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d, shifted, diff, a_n;
    logic [WIDTH-1:0] q_q, q_d, m_q, m_d, q_n;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, quo_fin, rem_fin;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d, accept;

    assign accept  = state_q == IDLE && bus.start && bus.divisor != '0;
    assign shifted = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, m_q};
    assign a_n     = diff[WIDTH] ? shifted : diff;
    assign q_n     = {q_q[WIDTH-2:0], ~diff[WIDTH]};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic qneg_q, rneg_q;

    assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dvs_mag = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
    assign quo_fin = qneg_q ? -q_n : q_n;
    assign rem_fin = rneg_q ? -a_n[WIDTH-1:0] : a_n[WIDTH-1:0];

    // Remember the result signs of the accepted operation for the fix-up on DONE entry
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (accept) begin
            qneg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            rneg_q <= bus.dividend[WIDTH-1];
        end
    end
`else
    assign dvd_mag = bus.dividend;
    assign dvs_mag = bus.divisor;
    assign quo_fin = q_n;
    assign rem_fin = a_n[WIDTH-1:0];
`endif

    // Next state, iteration datapath and result capture
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    q_d     = dvd_mag;
                    m_d     = dvs_mag;
                    a_d     = '0;
                    cnt_d   = '0;
                end else if (bus.start) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rem_d   = bus.dividend;
                    dbz_d   = 1'b1;
                end
            end
            CALC: begin
                a_d   = a_n;
                q_d   = q_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    quo_d   = quo_fin;
                    rem_d   = rem_fin;
                    dbz_d   = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = state_q == CALC;
    assign bus.done        = state_q == DONE;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
